adc_read_ad7476: RTL and testbench
==================================

# adc_read_ad7476

Serial read controller for the 12-bit AD7476-style SPI ADC (three-wire: CS, SCLK, SDATA). It is the read-side companion to the AD5626 DAC writer, and uses the same `set`/`busy`-style strobe handshake and clock-divided serial timing. One `start` strobe runs one 16-SCLK conversion frame. At the end of the frame the 12-bit result is presented with a one-cycle `valid` pulse. It sits between the ADC pins and the lab top-level logic.

## Interface
Parameters:
- `DELAY_FACTOR`, default 10: `clk` cycles per serial tick. Legal values are ≥4, so the SDATA synchronizer and the ADC output delay settle before sampling.

Ports (clock and reset first):
- `clk`  input  1  onboard 100 MHz clock; everything is on its rising edge
- `rst_n`  input  1  synchronous, active-low reset
- `start`  input  1  conversion request; accepted when `busy`=0
- `sdata`  input  1  ADC serial data pin (asynchronous to `clk`)
- `busy`  output  1  high from acceptance of `start` until the frame completes
- `valid`  output  1  one-`clk` pulse when `data`/`fmt_err` update
- `data`  output  12  last conversion result, unsigned, held until the next `valid`
- `fmt_err`  output  1  set with `valid` if any of the 4 leading frame bits was 1
- `cs`  output  1  ADC chip select, active low
- `sclk`  output  1  ADC serial clock, idles low

## Operation
- **Reset** (`rst_n`=0 at a `clk` edge) forces the following, regardless of state:
  - outputs: `cs`=1, `sclk`=0, `busy`=0, `valid`=0, `data`=0, `fmt_err`=0
  - internal: state=IDLE, divider=0, shift register=0, bit counter=15
- **SDATA input:** passes through a 2-flop synchronizer. Only the synchronized value is sampled.
- **Start acceptance:** when `busy`=0 and `start`=1, `busy` goes to 1 at that edge and the divider clears to 0.
  - `start` is ignored while `busy`=1, including the cycle in which `valid` pulses.
- **Divider:** counts 0..DELAY_FACTOR-1. A "tick" is the edge at which it equals DELAY_FACTOR-1 and wraps to 0. The FSM advances only on ticks.
- **FSM states:**
  - IDLE: on a tick with `busy`=1, set `cs`←0, `sclk`←0, bit counter←15, then go to SCLK_HI.
  - SCLK_HI: on a tick, set `sclk`←1, shift the synchronized `sdata` into the shift register LSB (shift left, 16 bits), then go to SCLK_LO.
  - SCLK_LO: on a tick, set `sclk`←0.
    - If bit counter=0: set `cs`←1 and go to QUIET.
    - Otherwise: decrement the bit counter and go to SCLK_HI.
  - QUIET: on a tick:
    - `data`←shift[11:0]
    - `fmt_err`←OR of shift[15:12]
    - `valid`←1 for this one `clk` cycle
    - `busy`←0
    - then go to IDLE.
- **Frame format:** exactly 16 SCLK rising edges per frame, MSB first. Bits 15:12 are the expected leading zeros; bits 11:0 are the result.
- **ADC-side timing:** the ADC changes SDATA on SCLK falling edges and on the CS falling edge. The controller samples on its own SCLK-rising tick.

## Timing
- Frame length is 34 ticks from the start-accept edge: IDLE 1 + 16×(HI+LO) + QUIET 1.
  - Consequently `valid`/`busy` fall occur exactly 34×DELAY_FACTOR `clk` after the start-accept edge. With DELAY_FACTOR=10 this is 340 clk = 3.4 µs.
- SCLK high and low phases are each DELAY_FACTOR `clk` cycles. SCLK frequency is 100 MHz/(2·DELAY_FACTOR).
- `cs` falls 1 tick after acceptance. It rises on the final SCLK falling edge, i.e. coincident with the last `sclk`←0.
- **Back-to-back frames** (`start` held high): the next start is accepted 1 `clk` after `busy` falls. `cs` stays high ≥2 ticks between frames (ADC quiet time).
- **Data hold:** `data`/`fmt_err` change only on the `valid` edge or on reset. They are stable otherwise.
- **Reset mid-frame:** the frame is abandoned with no `valid`. `cs` returns high at the reset edge. The next `start` after reset runs a full, correct frame.

## Test plan
Bench ADC model: drives the 16-bit word MSB first; bit 15 on the `cs` falling edge, each subsequent bit on an `sclk` falling edge. DELAY_FACTOR=4 unless noted.
- **Reset:** hold `rst_n`=0 for 3 cycles with `start`=1 → `cs`=1, `sclk`=0, `busy`=0, `valid`=0, `data`=0x000, `fmt_err`=0 throughout.
- **Single frame 0x0ABC:** pulse `start` for 1 cycle → `busy` asserts next edge; exactly 16 `sclk` rising edges while `cs`=0; one `valid` pulse 136 clk after accept; `data`=0xABC, `fmt_err`=0.
- **Extremes:** frames 0x0000 then 0x0FFF → `data`=0x000 then 0xFFF, `fmt_err`=0. Rerun with DELAY_FACTOR=10: `valid` at 340 clk.
- **Format error:** frame 0x8123 → `data`=0x123, `fmt_err`=1. Next frame 0x0123 → `fmt_err`=0.
- **Continuous start:** hold `start`=1 for 3 frames (0x0111, 0x0222, 0x0333) → 3 `valid` pulses, each 34×4+1 clk apart; `cs` high ≥8 clk between frames; extra `start` pulses while busy cause no extra frames.
- **Mid-frame reset:** assert `rst_n`=0 for 1 cycle after the 7th `sclk` rise → `cs`=1/`busy`=0 at that edge, no `valid`, `data` unchanged at 0x000; a following frame 0x0555 reads `data`=0x555.

Source files
------------

// File: rtl/adc_read_ad7476.sv
// Serial read controller for a 12-bit AD7476-style ADC: one start strobe runs a
// 16-SCLK frame and presents the 12-bit result with a one-cycle valid pulse.
module adc_read_ad7476 #(
  parameter int DELAY_FACTOR = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sdata,
  output logic        busy,
  output logic        valid,
  output logic [11:0] data,
  output logic        fmt_err,
  output logic        cs,
  output logic        sclk,
  output logic [1:0]  dbg_state
);

  // Handshake: start is accepted on any clk edge where busy=0 and start=1;
  // busy stays high until the edge that pulses valid, and start is ignored
  // for that whole interval.

  localparam int DW = $clog2(DELAY_FACTOR + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(DELAY_FACTOR - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCLK_HI = 2'd1,
    SCLK_LO = 2'd2,
    QUIET   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [15:0]   shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic [11:0]   data_q, data_d;
  logic          fmt_err_q, fmt_err_d;
  logic          sync1_q, sync2_q;
  logic          tick;

  assign tick = (div_q == DIV_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= 4'd15;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      fmt_err_q <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      fmt_err_q <= fmt_err_d;
      sync1_q   <= sdata;
      sync2_q   <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = tick ? '0 : div_q + 1'b1;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    fmt_err_d = fmt_err_q;

    // Clearing the divider on acceptance makes the first tick land exactly
    // DELAY_FACTOR clocks later, so frame timing is independent of start phase.
    if (!busy_q && start) begin
      busy_d = 1'b1;
      div_d  = '0;
    end

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (busy_q) begin
            cs_d      = 1'b0;
            sclk_d    = 1'b0;
            bit_cnt_d = 4'd15;
            state_d   = SCLK_HI;
          end
        end
        SCLK_HI: begin
          sclk_d  = 1'b1;
          shift_d = {shift_q[14:0], sync2_q};
          state_d = SCLK_LO;
        end
        SCLK_LO: begin
          sclk_d = 1'b0;
          if (bit_cnt_q == 4'd0) begin
            cs_d    = 1'b1;
            state_d = QUIET;
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
            state_d   = SCLK_HI;
          end
        end
        QUIET: begin
          data_d    = shift_q[11:0];
          fmt_err_d = |shift_q[15:12];
          valid_d   = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign data      = data_q;
  assign fmt_err   = fmt_err_q;
  assign cs        = cs_q;
  assign sclk      = sclk_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adc_read_ad7476.sv
// Directed bench for adc_read_ad7476: frame vector table on a DELAY_FACTOR=4
// instance plus hand sequences for back-to-back frames, mid-frame reset and DF=10.
module tb_adc_read_ad7476;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start4 = 1'b0, start10 = 1'b0;
  logic        sdata4 = 1'b0, sdata10 = 1'b0;
  logic        busy4, valid4, fmt_err4, cs4, sclk4;
  logic        busy10, valid10, fmt_err10, cs10, sclk10;
  logic [11:0] data4, data10;
  logic [1:0]  st4, st10;

  always #5 clk = ~clk;

  adc_read_ad7476 #(.DELAY_FACTOR(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sdata(sdata4),
    .busy(busy4), .valid(valid4), .data(data4), .fmt_err(fmt_err4),
    .cs(cs4), .sclk(sclk4), .dbg_state(st4)
  );

  adc_read_ad7476 #(.DELAY_FACTOR(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .sdata(sdata10),
    .busy(busy10), .valid(valid10), .data(data10), .fmt_err(fmt_err10),
    .cs(cs10), .sclk(sclk10), .dbg_state(st10)
  );

  // ADC models: bit 15 on CS fall, later bits on SCLK falls
  logic [15:0] adc_word = 16'h0;
  int idx4 = -1, idx10 = -1;
  always @(negedge cs4) begin sdata4 = adc_word[15]; idx4 = 14; end
  always @(negedge sclk4) if (!cs4 && idx4 >= 0) begin sdata4 = adc_word[idx4]; idx4--; end
  always @(negedge cs10) begin sdata10 = adc_word[15]; idx10 = 14; end
  always @(negedge sclk10) if (!cs10 && idx10 >= 0) begin sdata10 = adc_word[idx10]; idx10--; end

  int rise_all[2] = '{0, 0};
  int rise_lo[2]  = '{0, 0};
  int valid_cnt[2] = '{0, 0};
  always @(posedge sclk4)  begin rise_all[0]++; if (!cs4)  rise_lo[0]++; end
  always @(posedge sclk10) begin rise_all[1]++; if (!cs10) rise_lo[1]++; end
  always @(negedge clk) begin
    if (valid4)  valid_cnt[0]++;
    if (valid10) valid_cnt[1]++;
  end

  int hi_run = 0;
  int gap_n = 8;
  int gaps[8];
  always @(negedge clk) begin
    if (cs4) hi_run++;
    else begin
      if (hi_run > 0 && gap_n < 8) begin gaps[gap_n] = hi_run; gap_n++; end
      hi_run = 0;
    end
  end

  int n_pass = 0, n_total = 0;
  logic [11:0] prev_data[2] = '{12'h0, 12'h0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic run_frame(input int sel, input logic [15:0] w,
                           input logic [11:0] ed, input logic ee, input string nm);
    int lat, lat_exp, vbase;
    bit got;
    lat_exp = (sel == 1) ? 340 : 136;
    adc_word = w;
    rise_all[sel] = 0; rise_lo[sel] = 0;
    vbase = valid_cnt[sel];
    if (sel == 1) start10 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; start10 = 1'b0;
    check({nm, "_busy_on"}, (sel == 1) ? busy10 : busy4, 1);
    lat = 0; got = 0;
    while (!got && lat < lat_exp + 50) begin
      @(negedge clk);
      lat++;
      if (lat == lat_exp / 2)
        check({nm, "_data_hold"}, (sel == 1) ? data10 : data4, prev_data[sel]);
      if ((sel == 1) ? valid10 : valid4) got = 1;
    end
    check({nm, "_latency"}, lat, lat_exp);
    check({nm, "_data"}, (sel == 1) ? data10 : data4, ed);
    check({nm, "_fmt_err"}, (sel == 1) ? fmt_err10 : fmt_err4, ee);
    check({nm, "_busy_off"}, (sel == 1) ? busy10 : busy4, 0);
    check({nm, "_sclk_rises"}, rise_all[sel], 16);
    check({nm, "_rises_cs_low"}, rise_lo[sel], 16);
    @(negedge clk);
    check({nm, "_valid_1cyc"}, (sel == 1) ? valid10 : valid4, 0);
    check({nm, "_valid_count"}, valid_cnt[sel] - vbase, 1);
    prev_data[sel] = ed;
  endtask

  typedef struct {
    logic [15:0] word;
    logic [11:0] exp_data;
    logic        exp_err;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int n, vbase;
    logic [11:0] cont_exp[3];
    logic [15:0] cont_word[3];

    vecs[0] = '{16'h0ABC, 12'hABC, 1'b0};
    vecs[1] = '{16'h0000, 12'h000, 1'b0};
    vecs[2] = '{16'h0FFF, 12'hFFF, 1'b0};
    vecs[3] = '{16'h8123, 12'h123, 1'b1};
    vecs[4] = '{16'h0123, 12'h123, 1'b0};
    vecs[5] = '{16'h1000, 12'h000, 1'b1};
    vecs[6] = '{16'h4A5A, 12'hA5A, 1'b1};

    // Reset held with start asserted
    start4 = 1'b1; start10 = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_outputs_%0d", i),
            {cs4, sclk4, busy4, valid4, data4, fmt_err4, st4}, {1'b1, 3'b000, 12'h000, 1'b0, 2'b00});
    end
    check("reset_outputs_df10", {cs10, sclk10, busy10, valid10, data10, fmt_err10},
          {1'b1, 3'b000, 12'h000, 1'b0});
    start4 = 1'b0; start10 = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_frame(0, vecs[i].word, vecs[i].exp_data, vecs[i].exp_err, $sformatf("vec%0d", i));

    run_frame(1, 16'h0000, 12'h000, 1'b0, "df10_zero");
    run_frame(1, 16'h0FFF, 12'hFFF, 1'b0, "df10_full");

    // Mid-frame reset after the 7th SCLK rise
    adc_word = 16'h0FFF;
    rise_all[0] = 0;
    vbase = valid_cnt[0];
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (rise_all[0] < 7 && n < 1000) begin @(negedge clk); n++; end
    check("midrst_rise7", rise_all[0], 7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_cs_busy_sclk", {cs4, busy4, sclk4}, 3'b100);
    check("midrst_data", data4, 12'h000);
    repeat (200) @(negedge clk);
    check("midrst_no_valid", valid_cnt[0] - vbase, 0);
    check("midrst_idle", {cs4, busy4, data4}, {2'b10, 12'h000});
    prev_data[0] = 12'h000;
    run_frame(0, 16'h0555, 12'h555, 1'b0, "after_midrst");

    // Continuous start over three frames
    cont_word[0] = 16'h0111; cont_word[1] = 16'h0222; cont_word[2] = 16'h0333;
    cont_exp[0]  = 12'h111;  cont_exp[1]  = 12'h222;  cont_exp[2]  = 12'h333;
    adc_word = cont_word[0];
    vbase = valid_cnt[0];
    gap_n = 0;
    start4 = 1'b1;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!valid4 && n < 1000);
      if (f == 2) start4 = 1'b0;
      else adc_word = cont_word[f + 1];
      check($sformatf("cont_spacing_%0d", f), n, 137);
      check($sformatf("cont_data_%0d", f), data4, cont_exp[f]);
      check($sformatf("cont_fmt_err_%0d", f), fmt_err4, 0);
    end
    repeat (200) @(negedge clk);
    check("cont_valid_count", valid_cnt[0] - vbase, 3);
    check("cont_idle_after", {busy4, cs4}, 2'b01);
    check("cont_cs_falls", gap_n, 3);
    check("cont_cs_gap_1", gaps[1], 9);
    check("cont_cs_gap_2", gaps[2], 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
